// File: rtl/audio_sample_fifo.sv
`timescale 1ns/1ps
// audio_sample_fifo: elastic buffer behind the I2S receiver.
// Stores {channel, sample} pairs. The head entry falls through to the output.
// Samples that arrive while the FIFO is full are dropped, and each drop is counted.
module audio_sample_fifo #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_SIZE-1:0]     sample_data,
  input  logic                     sample_ch,
  input  logic                     sample_valid,
  output logic [DATA_SIZE-1:0]     out_data,
  output logic                     out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     drop_count,
  input  logic                     overflow_clr
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_SIZE + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level_nxt;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               drop;

  // Handshake qualification; a pop at full frees the slot for a same-cycle push
  always_comb begin
    pop     = out_valid & out_ready;
    full    = (level == LVL_W'(DEPTH));
    push_ok = sample_valid & (~full | pop);
    drop    = sample_valid & full & ~pop;
  end

  // Next occupancy from the push/pop combination
  always_comb begin
    level_nxt = level;
    case ({push_ok, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Sample storage; cleared on reset so the idle output reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= {sample_ch, sample_data};
    end
  end

  // Pointers, occupancy and valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
    end
  end

  // Drop tracking; a drop in the same cycle as a clear restarts the count at one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr)           drop_count <= CNT_WIDTH'(1);
      else if (drop_count != '1)  drop_count <= drop_count + CNT_WIDTH'(1);
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // First-word fall-through head
  assign out_data = mem[rd_ptr][DATA_SIZE-1:0];
  assign out_ch   = mem[rd_ptr][DATA_SIZE];

endmodule

// File: tb/tb_audio_sample_fifo.sv
`timescale 1ns/1ps
// Self-checking bench for audio_sample_fifo (DATA_SIZE=16, DEPTH=4, CNT_WIDTH=4)
module tb_audio_sample_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          sample_ch = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_ch;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    level;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic          overflow_clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: ordered queue of {ch, data}, sticky flag and saturating counter
  logic [DW:0] q[$];
  bit          m_ov;
  int          m_cnt;

  audio_sample_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .drop_count(drop_count),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    q.delete();
    m_ov  = 0;
    m_cnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1ns after
  task automatic step(input bit push, input logic [DW-1:0] d, input bit ch,
                      input bit rdy, input bit clr);
    bit was_full, do_pop;
    sample_valid = push; sample_data = d; sample_ch = ch;
    out_ready = rdy; overflow_clr = clr;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    do_pop   = rdy && (q.size() != 0);
    if (do_pop) void'(q.pop_front());
    if (push && (!was_full || do_pop)) q.push_back({ch, d});
    if (push && was_full && !do_pop) begin
      m_ov  = 1;
      m_cnt = clr ? 1 : ((m_cnt == 15) ? 15 : m_cnt + 1);
    end else if (clr) begin
      m_ov  = 0;
      m_cnt = 0;
    end
    #1;
    sample_valid = 0; out_ready = 0; overflow_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    #1;
    n_checks++; if (level !== 3'd0) $display("FAIL reset_level got %0d exp 0", level); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0000) $display("FAIL reset_data got %h exp 0000", out_data); else n_pass++;
    n_checks++; if (out_ch !== 1'b0) $display("FAIL reset_ch got %b exp 0", out_ch); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else n_pass++;
    n_checks++; if (drop_count !== 4'd0) $display("FAIL reset_drop_count got %0d exp 0", drop_count); else n_pass++;
  endtask

  task automatic test_ordering();
    for (int i = 0; i < 3; i++) step(1, 16'(16'h1111 * (i + 1)), i[0], 0, 0);
    n_checks++; if (level !== 3'd3) $display("FAIL order_level got %0d exp 3", level); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(16'h1111 * (i + 1)) || out_ch !== i[0])
        $display("FAIL order_head%0d got v=%b %h/%b exp 1 %h/%b", i, out_valid, out_data, out_ch,
                 16'(16'h1111 * (i + 1)), i[0]);
      else n_pass++;
      step(0, '0, 0, 1, 0);
    end
    n_checks++; if (out_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL order_empty got v=%b lvl=%0d exp 0 0", out_valid, level); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) step(1, 16'(16'hA000 + i), i[0], 0, 0);
    n_checks++; if (level !== 3'd4) $display("FAIL ovf_level got %0d exp 4", level); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else n_pass++;
    n_checks++; if (drop_count !== 4'd2) $display("FAIL ovf_count got %0d exp 2", drop_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data !== 16'(16'hA000 + i)) $display("FAIL ovf_drain%0d got %h exp %h", i, out_data, 16'(16'hA000 + i));
      else n_pass++;
      step(0, '0, 0, 1, 0);
    end
    step(0, '0, 0, 0, 1);
    n_checks++; if (overflow !== 1'b0 || drop_count !== 4'd0)
      $display("FAIL ovf_clear got %b/%0d exp 0/0", overflow, drop_count); else n_pass++;
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 4; i++) step(1, 16'(16'hB000 + i), 0, 0, 0);
    step(1, 16'hB004, 1, 1, 0);
    n_checks++; if (level !== 3'd4) $display("FAIL pp_level got %0d exp 4", level); else n_pass++;
    n_checks++; if (drop_count !== 4'd0 || overflow !== 1'b0)
      $display("FAIL pp_nodrop got %b/%0d exp 0/0", overflow, drop_count); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (out_data !== 16'(16'hB000 + i)) $display("FAIL pp_drain%0d got %h exp %h", i, out_data, 16'(16'hB000 + i));
      else n_pass++;
      step(0, '0, 0, 1, 0);
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL pp_empty got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_clear_race();
    for (int i = 0; i < 7; i++) step(1, 16'(16'hD000 + i), 0, 0, 0);
    n_checks++; if (drop_count !== 4'd3) $display("FAIL race_pre got %0d exp 3", drop_count); else n_pass++;
    step(1, 16'hD00F, 0, 0, 1);
    n_checks++; if (overflow !== 1'b1 || drop_count !== 4'd1)
      $display("FAIL race_drop_wins got %b/%0d exp 1/1", overflow, drop_count); else n_pass++;
    step(0, '0, 0, 0, 1);
    n_checks++; if (overflow !== 1'b0 || drop_count !== 4'd0)
      $display("FAIL race_clear got %b/%0d exp 0/0", overflow, drop_count); else n_pass++;
    for (int i = 0; i < 17; i++) step(1, 16'(i), 0, 0, 0);
    n_checks++; if (overflow !== 1'b1 || drop_count !== 4'hF)
      $display("FAIL race_saturate got %b/%h exp 1/f", overflow, drop_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data !== 16'(16'hD000 + i)) $display("FAIL race_drain%0d got %h exp %h", i, out_data, 16'(16'hD000 + i));
      else n_pass++;
      step(0, '0, 0, 1, 0);
    end
    step(0, '0, 0, 0, 1);
  endtask

  task automatic test_wrap_and_async_reset();
    logic [DW:0] head;
    for (int i = 0; i < 10; i++) begin
      step(1, 16'(16'hE000 + i), i[0], (i >= 2) && (i % 3 != 0), 0);
      head = q[0];
      n_checks++;
      if (level !== 3'(q.size()) || {out_ch, out_data} !== head)
        $display("FAIL wrap%0d got lvl=%0d %b/%h exp lvl=%0d %b/%h", i, level, out_ch, out_data,
                 q.size(), head[DW], head[DW-1:0]);
      else n_pass++;
    end
    while (q.size() > 2) step(0, '0, 0, 1, 0);
    n_checks++; if (level !== 3'd2) $display("FAIL areset_pre_level got %0d exp 2", level); else n_pass++;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0 || out_ch !== 1'b0 ||
        overflow !== 1'b0 || drop_count !== 4'd0)
      $display("FAIL areset got lvl=%0d v=%b %h/%b ov=%b cnt=%0d exp all 0", level, out_valid,
               out_data, out_ch, overflow, drop_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    step(1, 16'hC0DE, 1, 0, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hC0DE || out_ch !== 1'b1 || level !== 3'd1)
      $display("FAIL areset_push got v=%b %h/%b lvl=%0d exp 1 c0de/1 1", out_valid, out_data, out_ch, level);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [DW:0] head;
    int pr;
    for (int c = 0; c < 500; c++) begin
      pr = (c / 100) % 2 == 0 ? 25 : 80;
      step($urandom_range(0, 99) < 70, 16'($urandom), 1'($urandom),
           $urandom_range(0, 99) < pr, $urandom_range(0, 19) == 0);
      n_checks++;
      if (level !== 3'(q.size()) || out_valid !== (q.size() != 0) ||
          overflow !== m_ov || drop_count !== 4'(m_cnt))
        $display("FAIL rand_status%0d got lvl=%0d v=%b ov=%b cnt=%0d exp lvl=%0d v=%b ov=%b cnt=%0d",
                 c, level, out_valid, overflow, drop_count, q.size(), q.size() != 0, m_ov, m_cnt);
      else n_pass++;
      if (q.size() != 0) begin
        head = q[0];
        n_checks++;
        if ({out_ch, out_data} !== head)
          $display("FAIL rand_head%0d got %b/%h exp %b/%h", c, out_ch, out_data, head[DW], head[DW-1:0]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_overflow();
    test_push_pop_full();
    test_clear_race();
    test_wrap_and_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Elastic buffer directly downstream of the I2S receiver. It captures each completed microphone sample together with its channel tag (the WS level that framed it). It presents the samples in order to a consumer through a valid/ready handshake. It also counts samples dropped on overflow, so the CPU/SPI side can read audio without sample-exact timing.

## Interface

Parameters:
- `DATA_SIZE`, 16: sample width in bits (8, 16, 24 or 32); must match the receiver.
- `DEPTH`, 16: number of FIFO entries; power of two, ≥ 2.
- `CNT_WIDTH`, 8: width of the dropped-sample counter.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `sample_data`  in  DATA_SIZE: completed sample from the receiver.
- `sample_ch`  in  1: channel of the sample (0 = left, 1 = right).
- `sample_valid`  in  1: one-cycle push strobe.
- `out_data`  out  DATA_SIZE: head-of-FIFO sample.
- `out_ch`  out  1: head-of-FIFO channel tag.
- `out_valid`  out  1: head entry is valid.
- `out_ready`  in  1: consumer accepts the head entry.
- `level`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky flag; at least one sample dropped since the last clear.
- `drop_count`  out  CNT_WIDTH: number of dropped samples; saturates at all-ones.
- `overflow_clr`  in  1: one-cycle clear of `overflow` and `drop_count`.

## Operation

- Storage: DEPTH × (DATA_SIZE+1) register array holding {ch, data}; write pointer and read pointer are each $clog2(DEPTH) bits and wrap DEPTH-1 → 0 naturally.
- pop = `out_valid` & `out_ready`. push_req = `sample_valid`.
- full = (level == DEPTH). empty = (level == 0).
- Push accepted when push_req & (!full | pop): entry written at write pointer, and the write pointer increments.
- Push while full with no pop in the same cycle is a drop: storage is unchanged, `overflow` is set, and `drop_count` increments unless already all-ones.
- Pop advances the read pointer. `out_valid` with `out_ready` and empty is impossible, because `out_valid` = !empty.
- Level update: +1 on accepted push only, −1 on pop only, unchanged on accepted push together with pop. An accepted push plus pop at full keeps level = DEPTH.
- First-word fall-through: `out_data`/`out_ch` are driven combinationally from the array at the read pointer. They are held stable while `out_valid` & !`out_ready`.
- `overflow_clr` in the same cycle as a drop: `overflow` = 1 and `drop_count` = 1 (the drop wins over the clear). `overflow_clr` alone: both are cleared to 0.
- No data-dependent processing. Samples pass bit-exact, MSB-first as delivered.
- Reset (`rst_n` low, any time, including mid-transfer): pointers = 0, level = 0, `out_valid` = 0, `overflow` = 0, `drop_count` = 0, array cleared to 0, so `out_data` = 0 and `out_ch` = 0. Contents in flight are discarded. A push on the first edge after deassertion is accepted normally.

## Timing

- Push at rising edge N: `level` and `out_valid` reflect it after edge N. Data is visible at the output in cycle N+1 when the FIFO was empty, so input-to-output latency is 1 cycle.
- Pop at edge N: the next entry is presented after edge N. A consumer holding `out_ready` high drains one entry per cycle.
- `overflow` and `drop_count` update at the edge of the dropping push.
- Receiver strobes arrive at most once per DATA_SIZE+1 cycles. The FIFO nonetheless sustains one push per cycle.

## Test plan

Bench parameters: DATA_SIZE=16, DEPTH=4, CNT_WIDTH=4.

- Reset check: after `rst_n` low → high, `level` = 0, `out_valid` = 0, `out_data` = 0x0000, `overflow` = 0, `drop_count` = 0.
- Ordering: push 0x1111/L, 0x2222/R, 0x3333/L with `out_ready` = 0 → `level` = 3 and head = 0x1111/L; then raise `out_ready` → 0x1111, 0x2222, 0x3333 appear on consecutive cycles with channel tags intact; `out_valid` falls after the third pop.
- Overflow: push 6 samples (0xA000..0xA005) with no reads → `level` = 4, `overflow` = 1, `drop_count` = 2; the drained data are 0xA000..0xA003.
- Push plus pop at full: with FIFO full of 0xB000..0xB003, push 0xB004 while `out_ready` = 1 → no drop, `level` = 4, `drop_count` unchanged; the drain continues 0xB001..0xB004.
- Clear race: with `drop_count` = 3, assert `overflow_clr` in the same cycle as a full-FIFO drop → `overflow` = 1 and `drop_count` = 1. A clear alone → both 0. 17 consecutive drops → `drop_count` saturates at 0xF.
- Reset mid-operation and pointer wrap: stream 10 samples through with interleaved reads so the pointers wrap twice, and check FIFO order. Assert `rst_n` with `level` = 2 → all outputs return to reset values immediately (asynchronous). The next push of 0xC0DE appears at the head one cycle later.
